load_store_unit: RTL and testbench

- Sits between the processor memory stage and the byte-addressed, big-endian 1024-byte data memory.
- Accepts one load or store request at a time and supports byte, halfword and word sizes.
- Loads are sign- or zero-extended.
- Sub-word stores are done as read-modify-write, because the memory writes only whole words.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane.sv | 58 +++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data memory size.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam int MEM_BYTES = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_lane.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational, no handshake.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte offset 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = word[31:24];
    case (offset)
      2'd0: byte_lane = word[31:24];
      2'd1: byte_lane = word[23:16];
      2'd2: byte_lane = word[15:8];
      default: byte_lane = word[7:0];
    endcase
    half_lane = offset[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_HALF: load_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_BYTE: begin
        case (offset)
          2'd0: merged[31:24] = wdata[7:0];
          2'd1: merged[23:16] = wdata[7:0];
          2'd2: merged[15:8]  = wdata[7:0];
          default: merged[7:0] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (offset[1]) merged[15:0] = wdata[15:0];
        else           merged[31:16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for a word-wide big-endian data memory; resp_valid 1 (error), 2 (load, word store)
// or 3 (sub-word store) cycles after accept; req_ready only in IDLE, responses cannot be stalled.
module load_store_unit #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = lsu_pkg::MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import lsu_pkg::*;

  localparam int AW1 = ADDR_W + 1;

  state_e            state, state_nxt;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              req_err;
  logic              word_store;
  logic [2:0]        size_bytes;
  logic [ADDR_W:0]   last_byte;
  logic [DATA_W-1:0] load_ext;
  logic [DATA_W-1:0] merged;

  assign accept     = req_valid && req_ready;
  assign word_store = req_we && (req_size == SZ_WORD);

  // Range check uses one extra bit so addresses near the top cannot wrap into range.
  always_comb begin
    size_bytes = 3'd4;
    case (req_size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
    last_byte = {1'b0, req_addr} + AW1'(size_bytes) - AW1'(1);
    req_err   = (req_size == SZ_RSVD)
             || ((req_size == SZ_HALF) && req_addr[0])
             || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
             || (last_byte >= AW1'(MEM_BYTES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    mem_wr     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)         state_nxt = RESP;
          else if (word_store) state_nxt = WR;
          else                 state_nxt = RD;
        end
      end
      RD:   state_nxt = we_q ? WR : RESP;
      WR: begin
        mem_wr    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  lsu_lane u_lane (
    .word        (mem_rdata),
    .wdata       (wdata_q),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_ext),
    .merged      (merged)
  );

  // Faulting requests never update mem_addr/mem_wdata, so memory sees nothing new.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      if (accept) begin
        we_q       <= req_we;
        uns_q      <= req_unsigned;
        size_q     <= req_size;
        off_q      <= req_addr[1:0];
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_err   <= req_err;
        if (!req_err) mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        if (!req_err && word_store) mem_wdata <= req_wdata;
      end
      if (state == RD) begin
        if (we_q) mem_wdata  <= merged;
        else      resp_rdata <= load_ext;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboarded bench for load_store_unit with a behavioural 1 KiB word memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = SZ_BYTE;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr_k;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } row_t;

  row_t sb[$];

  int          obs_lat, obs_wr_cnt, obs_wr_k;
  logic [31:0] obs_rdata, obs_wr_addr, obs_wr_data;
  logic        obs_err, obs_rdy_busy;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wr       (mem_wr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

  function automatic row_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rdata, logic err, int lat,
                              int wr_k, logic [31:0] wr_addr, logic [31:0] wr_data);
    row_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    r.rdata = rdata; r.err = err; r.lat = lat; r.wr_k = wr_k;
    r.wr_addr = wr_addr; r.wr_data = wr_data;
    return r;
  endfunction

  // Drives one request, keeps a junk store on the bus while busy, and records what comes back.
  task automatic run_req(input row_t r);
    obs_lat = 0; obs_wr_cnt = 0; obs_wr_k = 0; obs_rdata = '0; obs_err = 1'b0;
    obs_wr_addr = '0; obs_wr_data = '0; obs_rdy_busy = 1'b0;
    req_we = r.we; req_size = r.size; req_unsigned = r.uns;
    req_addr = r.addr; req_wdata = r.wdata; req_valid = 1'b1;
    sb.push_back(r);
    for (int i = 0; i < 16 && !req_ready; i++) @(negedge clk);
    if (req_ready) begin
      @(posedge clk);
      #1;
      req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h0; req_wdata = 32'hBAD0_BAD0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (req_ready) obs_rdy_busy = 1'b1;
        if (mem_wr) begin
          obs_wr_cnt++; obs_wr_k = k; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata;
        end
        if (resp_valid) begin
          obs_lat = k; obs_rdata = resp_rdata; obs_err = resp_err;
          break;
        end
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin failures++; $display("FAIL reset resp_rdata: got %h want 0", resp_rdata); end
    checks++; if (resp_err !== 1'b0) begin failures++; $display("FAIL reset resp_err: got %b want 0", resp_err); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset mem_wr: got %b want 0", mem_wr); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_loads();
    row_t t[$];
    row_t e;
    t.push_back(mk(0, SZ_BYTE, 0, 32'h10,  0, 32'hFFFF_FF80, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_BYTE, 1, 32'h11,  0, 32'h0000_00F1, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_HALF, 0, 32'h12,  0, 32'h0000_2233, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_HALF, 0, 32'h10,  0, 32'hFFFF_80F1, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_HALF, 1, 32'h10,  0, 32'h0000_80F1, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_BYTE, 0, 32'h11,  0, 32'hFFFF_FFF1, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_BYTE, 1, 32'h13,  0, 32'h0000_0033, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 1, 32'h10,  0, 32'h80F1_2233, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_BYTE, 0, 32'h3FF, 0, 32'h0000_0044, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_HALF, 0, 32'h3FE, 0, 32'h0000_3344, 0, 2, 0, 0, 0));
    foreach (t[i]) begin
      run_req(t[i]);
      e = sb.pop_front();
      checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL load[%0d] latency: got %0d want %0d", i, obs_lat, e.lat); end
      checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL load[%0d] rdata: got %h want %h", i, obs_rdata, e.rdata); end
      checks++; if (obs_err !== e.err) begin failures++; $display("FAIL load[%0d] err: got %b want %b", i, obs_err, e.err); end
      checks++; if (obs_wr_cnt !== 0) begin failures++; $display("FAIL load[%0d] mem_wr count: got %0d want 0", i, obs_wr_cnt); end
      checks++; if (obs_rdy_busy !== 1'b0) begin failures++; $display("FAIL load[%0d] req_ready while busy: got %b want 0", i, obs_rdy_busy); end
    end
  endtask

  task automatic test_stores();
    row_t t[$];
    row_t e;
    t.push_back(mk(1, SZ_BYTE, 0, 32'h13, 32'h0000_00AB, 0, 0, 3, 2, 32'h10, 32'h80F1_22AB));
    t.push_back(mk(1, SZ_HALF, 0, 32'h12, 32'hCAFE_1234, 0, 0, 3, 2, 32'h10, 32'h80F1_1234));
    t.push_back(mk(1, SZ_BYTE, 1, 32'h10, 32'h1234_565A, 0, 0, 3, 2, 32'h10, 32'h5AF1_1234));
    t.push_back(mk(1, SZ_WORD, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 2, 1, 32'h20, 32'hDEAD_BEEF));
    t.push_back(mk(0, SZ_WORD, 0, 32'h20, 0, 32'hDEAD_BEEF, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h10, 0, 32'h5AF1_1234, 0, 2, 0, 0, 0));
    t.push_back(mk(1, SZ_BYTE, 0, 32'h21, 32'h0000_0080, 0, 0, 3, 2, 32'h20, 32'hDE80_BEEF));
    t.push_back(mk(0, SZ_BYTE, 0, 32'h21, 0, 32'hFFFF_FF80, 0, 2, 0, 0, 0));
    foreach (t[i]) begin
      run_req(t[i]);
      e = sb.pop_front();
      checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL store[%0d] latency: got %0d want %0d", i, obs_lat, e.lat); end
      checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL store[%0d] rdata: got %h want %h", i, obs_rdata, e.rdata); end
      checks++; if (obs_err !== e.err) begin failures++; $display("FAIL store[%0d] err: got %b want %b", i, obs_err, e.err); end
      checks++; if (obs_wr_cnt !== (e.wr_k != 0 ? 1 : 0)) begin failures++; $display("FAIL store[%0d] mem_wr count: got %0d want %0d", i, obs_wr_cnt, (e.wr_k != 0 ? 1 : 0)); end
      checks++; if (obs_wr_k !== e.wr_k) begin failures++; $display("FAIL store[%0d] mem_wr cycle: got %0d want %0d", i, obs_wr_k, e.wr_k); end
      checks++; if (obs_wr_addr !== e.wr_addr) begin failures++; $display("FAIL store[%0d] mem_addr: got %h want %h", i, obs_wr_addr, e.wr_addr); end
      checks++; if (obs_wr_data !== e.wr_data) begin failures++; $display("FAIL store[%0d] mem_wdata: got %h want %h", i, obs_wr_data, e.wr_data); end
    end
  endtask

  task automatic test_errors();
    row_t t[$];
    row_t e;
    t.push_back(mk(0, SZ_WORD, 0, 32'h22,        0,            0, 1, 1, 0, 0, 0));
    t.push_back(mk(1, SZ_HALF, 0, 32'h21,        32'h1111,     0, 1, 1, 0, 0, 0));
    t.push_back(mk(0, SZ_RSVD, 0, 32'h10,        0,            0, 1, 1, 0, 0, 0));
    t.push_back(mk(1, SZ_RSVD, 0, 32'h10,        32'h7777,     0, 1, 1, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h3FE,       0,            0, 1, 1, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h400,       0,            0, 1, 1, 0, 0, 0));
    t.push_back(mk(1, SZ_BYTE, 0, 32'h400,       32'h55,       0, 1, 1, 0, 0, 0));
    t.push_back(mk(1, SZ_WORD, 0, 32'h400,       32'h9999_0000, 0, 1, 1, 0, 0, 0));
    t.push_back(mk(0, SZ_HALF, 0, 32'h3FF,       0,            0, 1, 1, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'hFFFF_FFFC, 0,            0, 1, 1, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h0,         0, 32'h00C0_FFEE, 0, 2, 0, 0, 0));
    t.push_back(mk(0, SZ_WORD, 0, 32'h10,        0, 32'h5AF1_1234, 0, 2, 0, 0, 0));
    foreach (t[i]) begin
      run_req(t[i]);
      e = sb.pop_front();
      checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL err[%0d] latency: got %0d want %0d", i, obs_lat, e.lat); end
      checks++; if (obs_err !== e.err) begin failures++; $display("FAIL err[%0d] resp_err: got %b want %b", i, obs_err, e.err); end
      checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL err[%0d] rdata: got %h want %h", i, obs_rdata, e.rdata); end
      checks++; if (obs_wr_cnt !== 0) begin failures++; $display("FAIL err[%0d] mem_wr count: got %0d want 0", i, obs_wr_cnt); end
    end
  endtask

  task automatic test_reset_mid_op();
    row_t e;
    logic seen_wr, seen_resp;
    seen_wr = 1'b0; seen_resp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'hEE; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_wr) seen_wr = 1'b1;
      if (resp_valid) seen_resp = 1'b1;
    end
    checks++; if (seen_wr !== 1'b0) begin failures++; $display("FAIL midrst mem_wr: got %b want 0", seen_wr); end
    checks++; if (seen_resp !== 1'b0) begin failures++; $display("FAIL midrst resp_valid: got %b want 0", seen_resp); end
    checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL midrst mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL midrst mem_wdata: got %h want 0", mem_wdata); end
    checks++; if ({resp_rdata, resp_err} !== 33'h0) begin failures++; $display("FAIL midrst resp: got %h/%b want 0/0", resp_rdata, resp_err); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst req_ready: got %b want 1", req_ready); end
    run_req(mk(0, SZ_WORD, 0, 32'h14, 0, 32'h0102_0304, 0, 2, 0, 0, 0));
    e = sb.pop_front();
    checks++; if (obs_lat !== e.lat) begin failures++; $display("FAIL midrst reload latency: got %0d want %0d", obs_lat, e.lat); end
    checks++; if (obs_rdata !== e.rdata) begin failures++; $display("FAIL midrst reload rdata: got %h want %h", obs_rdata, e.rdata); end
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0]   = 32'h00C0_FFEE;
    mem[4]   = 32'h80F1_2233;
    mem[5]   = 32'h0102_0304;
    mem[255] = 32'h1122_3344;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
